// File: rtl/grant_arbiter_pkg.sv
// Shared definitions for the four-requester round-robin grant arbiter.
// Contents:
//   state_e  - arbiter FSM states (IDLE, GRANT, HANDOFF)
//   NUM_REQ  - number of requesting agents
//   IDX_W    - width of a requester index
//   HOLD_W   - width of the hold-time counter
//   rr_pick  - round-robin winner selection starting at a priority pointer
package grant_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int HOLD_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_HANDOFF = 2'd2
  } state_e;

  // Returns the first requesting index in the order ptr, ptr+1, ... (mod 4).
  // When no request is set the result is ptr; callers qualify with |req.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/grant_arbiter_dec.sv
// 2-to-4 one-hot decoder used to drive the resource select lines.
// Ports:
//   idx_i       - 2-bit select index
//   onehot_o    - active-high one-hot decode of idx_i
//   onehot_n_o  - bitwise inverse of onehot_o (active-low enables)
module grant_arbiter_dec
  import grant_arbiter_pkg::*;
(
  input  logic [IDX_W-1:0]   idx_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [NUM_REQ-1:0] onehot_n_o
);

  always_comb begin
    onehot_o        = '0;
    onehot_o[idx_i] = 1'b1;
  end

  assign onehot_n_o = ~onehot_o;

endmodule

// File: rtl/grant_arbiter.sv
// Four-requester round-robin arbiter with a one-cycle dead slot between
// owners and hold-limit preemption.
// Parameters:
//   MAX_HOLD - grant cycles after which an owner is preempted when another
//              request is pending (1..255)
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   req     - level-sensitive request per agent
//   gnt_idx - registered index of the current/last owner
//   gnt     - one-hot active-high grant, 0000 when no owner
//   gnt_n   - bitwise inverse of gnt
//   busy    - high while a grant is active
module grant_arbiter
  import grant_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] gnt_n,
  output logic               busy
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic [NUM_REQ-1:0]  dec_oh, dec_oh_n;
  logic [IDX_W-1:0]    next_ptr;
  logic                in_grant;
  logic                others_pending;

  grant_arbiter_dec u_dec (
    .idx_i      (gnt_idx_q),
    .onehot_o   (dec_oh),
    .onehot_n_o (dec_oh_n)
  );

  // Pointer the HANDOFF cycle arbitrates with; wraps 3 -> 0.
  assign next_ptr       = gnt_idx_q + IDX_W'(1);
  assign others_pending = |(req & ~dec_oh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_idx_q  <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_idx_d  = rr_pick(req, ptr_q);
          hold_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (hold_cnt_q < HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
        // Release wins over preemption; both leave through HANDOFF anyway.
        if (!req[gnt_idx_q]) begin
          state_d = ST_HANDOFF;
        end else if ((hold_cnt_q >= HOLD_LIM) && others_pending) begin
          state_d = ST_HANDOFF;
        end
      end
      ST_HANDOFF: begin
        ptr_d = next_ptr;
        if (|req) begin
          gnt_idx_d  = rr_pick(req, next_ptr);
          hold_cnt_d = '0;
          state_d    = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs depend only on registers, so reset clears the grant at once.
  assign in_grant = (state_q == ST_GRANT);
  assign gnt      = in_grant ? dec_oh   : '0;
  assign gnt_n    = in_grant ? dec_oh_n : '1;
  assign busy     = in_grant;
  assign gnt_idx  = gnt_idx_q;

endmodule

// File: tb/tb_grant_arbiter.sv
module tb_grant_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] gnt_idx;
  logic [3:0] gnt;
  logic [3:0] gnt_n;
  logic       busy;

  int n_checks;
  int n_fail;

  grant_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt_idx (gnt_idx),
    .gnt     (gnt),
    .gnt_n   (gnt_n),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       busy;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                         input logic eb);
    chk({tag, ".gnt"},   {4'h0, gnt},   {4'h0, eg});
    chk({tag, ".gnt_n"}, {4'h0, gnt_n}, {4'h0, ~eg});
    chk({tag, ".idx"},   {6'h0, gnt_idx}, {6'h0, ei});
    chk({tag, ".busy"},  {7'h0, busy},  {7'h0, eb});
  endtask

  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[26];

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // After reset: IDLE, ptr=0, MAX_HOLD=4.
    vecs[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[1]  = '{4'b1010, 4'b0010, 2'd1, 1'b1};
    vecs[2]  = '{4'b1000, 4'b0000, 2'd1, 1'b0};
    vecs[3]  = '{4'b1000, 4'b1000, 2'd3, 1'b1};
    vecs[4]  = '{4'b0000, 4'b0000, 2'd3, 1'b0};
    vecs[5]  = '{4'b0000, 4'b0000, 2'd3, 1'b0};
    vecs[6]  = '{4'b1001, 4'b0001, 2'd0, 1'b1};
    vecs[7]  = '{4'b1000, 4'b0000, 2'd0, 1'b0};
    vecs[8]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[9]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[10] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[11] = '{4'b0000, 4'b0000, 2'd2, 1'b0};
    vecs[12] = '{4'b0000, 4'b0000, 2'd2, 1'b0};
    vecs[13] = '{4'b0101, 4'b0001, 2'd0, 1'b1};
    vecs[14] = '{4'b0101, 4'b0001, 2'd0, 1'b1};
    vecs[15] = '{4'b0101, 4'b0001, 2'd0, 1'b1};
    vecs[16] = '{4'b0101, 4'b0001, 2'd0, 1'b1};
    vecs[17] = '{4'b0101, 4'b0000, 2'd0, 1'b0};
    vecs[18] = '{4'b0101, 4'b0100, 2'd2, 1'b1};
    vecs[19] = '{4'b0101, 4'b0100, 2'd2, 1'b1};
    vecs[20] = '{4'b0101, 4'b0100, 2'd2, 1'b1};
    vecs[21] = '{4'b0101, 4'b0100, 2'd2, 1'b1};
    vecs[22] = '{4'b0101, 4'b0000, 2'd2, 1'b0};
    vecs[23] = '{4'b0101, 4'b0001, 2'd0, 1'b1};
    vecs[24] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[25] = '{4'b0000, 4'b0000, 2'd0, 1'b0};

    // Reset held with all requests high.
    rst_n = 1'b0;
    req   = 4'b1111;
    #2;
    chk_all("reset_async", 4'b0000, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset_held", 4'b0000, 2'd0, 1'b0);
    req   = 4'b0000;
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      step(vecs[i].req);
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].busy);
      chk($sformatf("vec%0d.onehot", i), {7'h0, $onehot0(gnt)}, 8'h01);
    end

    // Lone owner (ptr=1): agent 3 keeps the grant with no dead cycle.
    for (int c = 0; c < 20; c++) begin
      step(4'b1000);
      chk($sformatf("lone%0d.gnt", c), {4'h0, gnt}, 8'h08);
    end
    step(4'b0000);
    chk_all("lone_rel", 4'b0000, 2'd3, 1'b0);
    step(4'b0000);
    chk_all("lone_idle", 4'b0000, 2'd3, 1'b0);

    // Same agent re-granted after a one-cycle drop still sees a dead slot.
    step(4'b0010);
    chk_all("regrant_a", 4'b0010, 2'd1, 1'b1);
    step(4'b0000);
    chk_all("regrant_dead", 4'b0000, 2'd1, 1'b0);
    step(4'b0010);
    chk_all("regrant_b", 4'b0010, 2'd1, 1'b1);

    // Reset mid-grant (ptr is 2 here) clears the grant between edges.
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("midreset", 4'b0000, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Reset ptr=0 picks agent 1; a surviving ptr=2 would pick agent 3.
    step(4'b1010);
    chk_all("post_reset", 4'b0010, 2'd1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grant_arbiter.md
# grant_arbiter

Four-requester round-robin arbiter that sequences ownership of a shared resource selected through the team's 2-to-4 one-hot decoder. It registers the winning requester index, drives it through the decoder to produce active-high one-hot grants and active-low enables, enforces a one-cycle dead slot between owners, and preempts an owner that holds the resource past a hold limit while others wait. It sits between the requesting agents and the resource select lines.

## Interface
- MAX_HOLD, 8, grant cycles after which an owner is preempted if another request is pending; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request per agent, level-sensitive; held high for as long as the agent wants the resource.
- gnt_idx  output  2  registered index of current/last owner.
- gnt  output  4  one-hot grant, active-high; 0000 when no owner.
- gnt_n  output  4  bitwise inverse of gnt (active-low enables).
- busy  output  1  high while in GRANT.

## Operation
- States: IDLE, GRANT, HANDOFF. Registers: state, gnt_idx[1:0], ptr[1:0] (highest-priority index), hold_cnt[7:0].
- Winner selection: first index i in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req[i]=1.
- IDLE: gnt=0000, busy=0. If req≠0: load gnt_idx with winner, clear hold_cnt, go GRANT. Else stay.
- GRANT: gnt=decode(gnt_idx), busy=1. hold_cnt increments each cycle, saturating at MAX_HOLD.
  - req[gnt_idx]=0 → HANDOFF (release).
  - else hold_cnt ≥ MAX_HOLD−1 and any other req bit set → HANDOFF (preempt).
  - else stay. Owner alone may hold indefinitely.
- HANDOFF: gnt=0000, busy=0; ptr ← gnt_idx+1 (mod 4, wraps 3→0). Winner selection in this cycle uses the updated ptr: if req≠0 load gnt_idx, clear hold_cnt, go GRANT; else go IDLE.
- Release and preempt in the same cycle: treated as release (same resulting path).
- gnt is forced to 0000 outside GRANT regardless of gnt_idx; gnt_n=~gnt always. Never more than one gnt bit high.
- Requests dropped before being granted are simply not considered; no request memory.

## Timing
- All state registered; no combinational path from req to gnt/gnt_n/busy.
- Grant latency from IDLE: req rises before edge t → gnt valid after edge t (1 cycle).
- Handoff: owner drops req before edge t → gnt=0000 after t; next owner's gnt after t+1. Exactly one dead cycle between any two owners, including same agent re-granted.
- Preemption: with competing request pending throughout, owner holds gnt for exactly MAX_HOLD cycles.
- Reset (asynchronous assert, synchronous deassert relative to clk): state=IDLE, gnt_idx=00, ptr=00, hold_cnt=0, gnt=0000, gnt_n=1111, busy=0. Reset mid-GRANT removes grant immediately without waiting for an edge.

## Structure
- Shared package: state enum (IDLE, GRANT, HANDOFF), NUM_REQ=4, IDX_W=2, HOLD_W=8.
- One sub-module: the existing 2-to-4 decoder, instanced on gnt_idx to produce the raw one-hot and inverted vectors; arbiter gates them with (state==GRANT). Priority selection and FSM stay in this module.

## Test plan
- Reset: hold rst_n low with req=1111 → gnt=0000, gnt_n=1111, busy=0, gnt_idx=00; release reset, req=0000 → remains IDLE.
- Single request: req=0100 from IDLE → next cycle gnt=0100, gnt_n=1011, gnt_idx=10, busy=1; drop req → 1 cycle gnt=0000, then IDLE.
- Simultaneous requests, ptr=0: req=1010 → agent 1 granted; release agent 1 → HANDOFF, ptr=2 → agent 3 granted; release → ptr wraps to 0.
- Preemption, MAX_HOLD=4: agent 0 granted, agent 2 requests continuously → agent 0 holds exactly 4 cycles, 1 dead cycle, agent 2 granted; agent 0 still requesting waits until agent 2 releases or is preempted.
- Lone owner: only req[3] high for 20 cycles with MAX_HOLD=4 → gnt=1000 continuously, no dead cycle.
- Reset mid-grant: assert rst_n low while gnt=0010 between edges → gnt=0000, gnt_n=1111 immediately; after release with req=0010 → re-granted with ptr=0 ordering.
